ltl_report_collector: RTL and testbench

//  Downstream stage of the per-cluster LTL monitor automata. It samples the automaton report vector
//  on every run cycle and tags each non-zero vector with the stream offset of its symbol.

---
 rtl/monitor_report_pkg.sv | 14 +
 rtl/ltl_report_collector_if.sv | 18 +
 rtl/report_fifo.sv | 54 +++++
 rtl/ltl_report_collector.sv | 84 ++++++++
 tb/tb_ltl_report_collector.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/monitor_report_pkg.sv
// Shared widths and the tagged-event record for the LTL monitor report path.
package monitor_report_pkg;

    localparam int DEFAULT_NUM_REPORTS = 4;
    localparam int DEFAULT_OFFSET_W    = 16;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_DROP_W      = 8;

    typedef struct packed {
        logic [DEFAULT_OFFSET_W-1:0]    offset;
        logic [DEFAULT_NUM_REPORTS-1:0] report;
    } report_entry_t;

endpackage

// File: rtl/ltl_report_collector_if.sv
// Drain port of the report collector toward the CSR/trace aggregator.
// Handshake: an entry moves on a posedge where out_valid && out_ready; while out_valid && !out_ready
// the producer holds out_offset/out_report stable and never drops out_valid before that transfer.
interface ltl_report_collector_if
    import monitor_report_pkg::*;
#(
    parameter int NUM_REPORTS = DEFAULT_NUM_REPORTS,
    parameter int OFFSET_W    = DEFAULT_OFFSET_W
);
    logic                   out_valid;
    logic                   out_ready;
    logic [OFFSET_W-1:0]    out_offset;
    logic [NUM_REPORTS-1:0] out_report;

    modport master (output out_valid, output out_offset, output out_report, input out_ready);
    modport slave  (input out_valid, input out_offset, input out_report, output out_ready);

endinterface

// File: rtl/report_fifo.sv
// Generic synchronous FIFO with async reset, synchronous flush and flop-driven head entry.
module report_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the indices coincide.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ltl_report_collector.sv
// Tags non-zero automaton report vectors with their symbol offset and queues them for draining,
// keeping sticky seen/overflow flags and a saturating drop counter.
module ltl_report_collector
    import monitor_report_pkg::*;
#(
    parameter int NUM_REPORTS = DEFAULT_NUM_REPORTS,
    parameter int OFFSET_W    = DEFAULT_OFFSET_W,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int DROP_W      = DEFAULT_DROP_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   clear,
    input  logic [NUM_REPORTS-1:0] report_in,
    ltl_report_collector_if.master out_if,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic [NUM_REPORTS-1:0] report_seen
);
    localparam int ENTRY_W = OFFSET_W + NUM_REPORTS;

    logic [OFFSET_W-1:0] off_q;
    logic [ENTRY_W-1:0]  head;
    logic                event_hit;
    logic                pop;
    logic                push;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;

    assign event_hit = run & (|report_in);
    assign pop       = out_if.out_valid & out_if.out_ready;
    // A full FIFO still takes the event when the head leaves on the same edge.
    assign push      = event_hit & ~clear & (~fifo_full | pop);
    assign drop      = event_hit & ~clear & fifo_full & ~pop;

    report_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (clear),
        .push      (push),
        .push_data ({off_q, report_in}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_if.out_valid  = ~fifo_empty;
    assign out_if.out_offset = head[ENTRY_W-1 -: OFFSET_W];
    assign out_if.out_report = head[NUM_REPORTS-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            off_q       <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            report_seen <= '0;
        end else if (clear) begin
            off_q       <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            report_seen <= '0;
        end else begin
            if (run) begin
                off_q       <= off_q + OFFSET_W'(1);
                report_seen <= report_seen | report_in;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Randomized and directed checks of ltl_report_collector against a queue-based reference model.
module tb_ltl_report_collector;
  import monitor_report_pkg::*;

  localparam int NR = 4;
  localparam int OW = 16;
  localparam int DEPTH = 8;
  localparam int DW = 8;
  localparam int W = OW + NR;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic clear = 1'b0;
  logic [NR-1:0] report_in = '0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow;
  logic [DW-1:0] drop_count;
  logic [NR-1:0] report_seen;

  ltl_report_collector_if #(.NUM_REPORTS(NR), .OFFSET_W(OW)) out_if ();

  ltl_report_collector #(
    .NUM_REPORTS(NR), .OFFSET_W(OW), .DEPTH(DEPTH), .DROP_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .report_in(report_in),
    .out_if(out_if), .fifo_count(fifo_count), .overflow(overflow),
    .drop_count(drop_count), .report_seen(report_seen)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  logic [OW-1:0] m_off;
  logic m_ovf;
  logic [DW-1:0] m_drop;
  logic [NR-1:0] m_seen;
  int errors = 0;
  int checks = 0;

  function automatic void model_reset();
    exp_q.delete();
    m_off = '0;
    m_ovf = 1'b0;
    m_drop = '0;
    m_seen = '0;
  endfunction

  // One clock edge of the spec rules applied to the current inputs.
  function automatic void model_edge();
    if (clear) begin
      model_reset();
      return;
    end
    if (out_if.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (run && report_in != '0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_off, report_in});
      else begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
    if (run) begin
      m_seen = m_seen | report_in;
      m_off = m_off + 16'd1;
    end
  endfunction

  // driver: apply inputs at a negedge, advance model, land on the next negedge
  task automatic tick(input bit r, input logic [NR-1:0] rep, input bit rdy, input bit clr);
    run = r;
    report_in = rep;
    out_if.out_ready = rdy;
    clear = clr;
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [NR-1:0] rnd_rep();
    return NR'($urandom_range(1, 15));
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    run = 1'b0; clear = 1'b0; report_in = '0; out_if.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_if.out_valid !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0 || drop_count !== '0 ||
        report_seen !== '0 || out_if.out_offset !== '0 || out_if.out_report !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b count=%0d ovf=%0b drop=%0d seen=%b off=%h rep=%b, want all 0",
               out_if.out_valid, fifo_count, overflow, drop_count, report_seen, out_if.out_offset, out_if.out_report);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_event();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (out_if.out_valid !== 1'b0) begin
        errors++; $display("FAIL first_idle_valid: got %0b want 0 (cycle %0d)", out_if.out_valid, i);
      end
    end
    tick(1'b1, 4'b0010, 1'b0, 1'b0);
    checks++;
    if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0b want 1", out_if.out_valid); end
    checks++;
    if (out_if.out_offset !== 16'd5) begin errors++; $display("FAIL first_offset: got %0d want 5", out_if.out_offset); end
    checks++;
    if (out_if.out_report !== 4'b0010) begin errors++; $display("FAIL first_report: got %b want 0010", out_if.out_report); end
    checks++;
    if (report_seen !== 4'b0010) begin errors++; $display("FAIL first_seen: got %b want 0010", report_seen); end
    tick(1'b0, 4'b1111, 1'b0, 1'b0);
    checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_offset !== 16'd5 || report_seen !== 4'b0010) begin
      errors++; $display("FAIL first_hold: valid=%0b off=%0d seen=%b want 1/5/0010",
                         out_if.out_valid, out_if.out_offset, report_seen);
    end
    tick(1'b0, 4'b0000, 1'b1, 1'b0);
    checks++;
    if (out_if.out_valid !== 1'b0 || fifo_count !== '0) begin
      errors++; $display("FAIL first_pop: valid=%0b count=%0d want 0/0", out_if.out_valid, fifo_count);
    end
  endtask

  task automatic test_ordered_pops();
    logic [W-1:0] e;
    int offs[3] = '{3, 4, 7};
    tick(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, (i == 3 || i == 4 || i == 7) ? rnd_rep() : 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      e = exp_q[0];
      checks++;
      if (fifo_count !== 4'(3 - k) || out_if.out_valid !== 1'b1 || out_if.out_offset !== 16'(offs[k]) ||
          out_if.out_report !== e[NR-1:0]) begin
        errors++;
        $display("FAIL order_pop%0d: count=%0d valid=%0b off=%0d rep=%b want %0d/1/%0d/%b",
                 k, fifo_count, out_if.out_valid, out_if.out_offset, out_if.out_report, 3 - k, offs[k], e[NR-1:0]);
      end
      tick(1'b0, 4'b0000, 1'b1, 1'b0);
    end
    checks++;
    if (fifo_count !== '0 || out_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL order_empty: count=%0d valid=%0b want 0/0", fifo_count, out_if.out_valid);
    end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [W-1:0] e;
    tick(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 3; i++) tick(1'b1, rnd_rep(), 1'b0, 1'b0);
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd3) begin
      errors++; $display("FAIL overflow_state: count=%0d ovf=%0b drop=%0d want 8/1/3", fifo_count, overflow, drop_count);
    end
    checks++;
    if (out_if.out_offset !== 16'd0) begin errors++; $display("FAIL overflow_head: got %0d want 0", out_if.out_offset); end
    // full FIFO, event arrives together with a pop
    tick(1'b1, 4'b1001, 1'b1, 1'b0);
    checks++;
    if (fifo_count !== 4'd8 || drop_count !== 8'd3 || overflow !== 1'b1) begin
      errors++; $display("FAIL full_pop_push: count=%0d drop=%0d ovf=%0b want 8/3/1", fifo_count, drop_count, overflow);
    end
    for (int k = 0; k < DEPTH; k++) begin
      e = exp_q[0];
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_offset !== ((k < 7) ? 16'(k + 1) : 16'd11) ||
          out_if.out_report !== e[NR-1:0]) begin
        errors++;
        $display("FAIL full_drain%0d: valid=%0b off=%0d rep=%b want 1/%0d/%b", k, out_if.out_valid,
                 out_if.out_offset, out_if.out_report, (k < 7) ? k + 1 : 11, e[NR-1:0]);
      end
      tick(1'b0, 4'b0000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_drop_saturate();
    tick(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 270; i++) tick(1'b1, rnd_rep(), 1'b0, 1'b0);
    checks++;
    if (drop_count !== 8'hFF || overflow !== 1'b1 || fifo_count !== 4'd8) begin
      errors++; $display("FAIL drop_saturate: drop=%0d ovf=%0b count=%0d want 255/1/8", drop_count, overflow, fifo_count);
    end
  endtask

  task automatic test_offset_wrap();
    logic [OW-1:0] want[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    tick(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 65534; i++) tick(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, rnd_rep(), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_offset !== want[k]) begin
        errors++; $display("FAIL wrap_offset%0d: valid=%0b off=%h want 1/%h", k, out_if.out_valid, out_if.out_offset, want[k]);
      end
      tick(1'b0, 4'b0000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_clear_priority();
    tick(1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b1, 4'(1 << (i % 4)), 1'b0, 1'b0);
    checks++;
    if (report_seen !== 4'b1111 || overflow !== 1'b1 || fifo_count !== 4'd8) begin
      errors++; $display("FAIL clear_pre: seen=%b ovf=%0b count=%0d want 1111/1/8", report_seen, overflow, fifo_count);
    end
    tick(1'b1, 4'b0101, 1'b1, 1'b1);
    checks++;
    if (out_if.out_valid !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0 || drop_count !== '0 || report_seen !== '0) begin
      errors++; $display("FAIL clear_all: valid=%0b count=%0d ovf=%0b drop=%0d seen=%b want all 0",
                         out_if.out_valid, fifo_count, overflow, drop_count, report_seen);
    end
    tick(1'b1, 4'b0001, 1'b0, 1'b0);
    checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_offset !== 16'd0 || fifo_count !== 4'd1) begin
      errors++; $display("FAIL clear_offset: valid=%0b off=%0d count=%0d want 1/0/1",
                         out_if.out_valid, out_if.out_offset, fifo_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) tick(1'b1, rnd_rep(), 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_if.out_valid !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0 || drop_count !== '0 ||
        report_seen !== '0 || out_if.out_offset !== '0 || out_if.out_report !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b count=%0d ovf=%0b drop=%0d seen=%b off=%h rep=%b want all 0",
               out_if.out_valid, fifo_count, overflow, drop_count, report_seen, out_if.out_offset, out_if.out_report);
    end
    run = 1'b0; report_in = '0; out_if.out_ready = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [NR-1:0] rep;
    for (int i = 0; i < 600; i++) begin
      rep = ($urandom_range(0, 2) == 0) ? 4'b0000 : rnd_rep();
      tick(1'($urandom_range(0, 3) != 0), rep, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      checks++;
      if (out_if.out_valid !== (exp_q.size() != 0) || fifo_count !== 4'(exp_q.size()) || overflow !== m_ovf ||
          drop_count !== m_drop || report_seen !== m_seen) begin
        errors++;
        $display("FAIL rand_state%0d: valid=%0b count=%0d ovf=%0b drop=%0d seen=%b want %0b/%0d/%0b/%0d/%b", i,
                 out_if.out_valid, fifo_count, overflow, drop_count, report_seen,
                 exp_q.size() != 0, exp_q.size(), m_ovf, m_drop, m_seen);
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        checks++;
        if ({out_if.out_offset, out_if.out_report} !== e) begin
          errors++; $display("FAIL rand_head%0d: off=%h rep=%b want off=%h rep=%b", i,
                             out_if.out_offset, out_if.out_report, e[W-1:NR], e[NR-1:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_ordered_pops();
    test_overflow_and_full_pop();
    test_drop_saturate();
    test_clear_priority();
    test_async_reset();
    test_random();
    test_offset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
